cpu_seq_ctrl: RTL and testbench

CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

---
 rtl/cpu_seq_pkg.sv | 23 ++
 rtl/pc_watchdog.sv | 46 ++++
 rtl/cpu_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and default parameter values for the CPU sequencing controller.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int DEF_PC_W      = 6;
    localparam int DEF_MEM_DIV   = 2;
    localparam int DEF_NUM_EN    = 1;
    localparam int DEF_FLUSH_CYC = 1;
    localparam int DEF_HALT_CYC  = 8;

    localparam logic [31:0] CYC_MAX = 32'hFFFF_FFFF;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pc_watchdog.sv
// PC stall watchdog: counts consecutive cycles in which the program counter
// has not changed and flags the cycle on which that count reaches HALT_CYC.
module pc_watchdog
    import cpu_seq_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int HALT_CYC = DEF_HALT_CYC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            clear,
    input  logic [PC_W-1:0] pc,
    output logic            stall_hit
);

    localparam int               CNT_W    = width_for(HALT_CYC);
    localparam logic [CNT_W-1:0] HIT_PREV = CNT_W'(HALT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(HALT_CYC);

    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] stall_cnt;
    logic             same_pc;

    assign same_pc = (pc == pc_q);

    // Raised on the cycle whose edge brings the count to HALT_CYC, so the
    // controller can move to HALT on that same edge.
    assign stall_hit = enable && same_pc && (stall_cnt == HIT_PREV);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            stall_cnt <= '0;
        end else begin
            pc_q <= pc;
            if (!enable || clear || !same_pc) begin
                stall_cnt <= '0;
            end else if (stall_cnt != CNT_TOP) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// CPU sequencing controller: FLUSH/RUN/HALT FSM, staggered memory enables and a
// PC stall watchdog. Define CPU_SEQ_CYCLE_COUNT_EN to build the RUN-cycle counter.
module cpu_seq_ctrl
    import cpu_seq_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int MEM_DIV   = DEF_MEM_DIV,
    parameter int NUM_EN    = DEF_NUM_EN,
    parameter int FLUSH_CYC = DEF_FLUSH_CYC,
    parameter int HALT_CYC  = DEF_HALT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pc,
    input  logic              restart,
    output logic              cpu_rst,
    output logic [NUM_EN-1:0] memen,
    output logic              running,
    output logic              halted,
    output logic [31:0]       cyc_cnt
);

    if (PC_W < 1) begin : g_bad_pc_w
        $fatal(1, "cpu_seq_ctrl: PC_W must be at least 1");
    end
    if (MEM_DIV < 1 || MEM_DIV > 16) begin : g_bad_mem_div
        $fatal(1, "cpu_seq_ctrl: MEM_DIV must be in 1..16");
    end
    if (NUM_EN < 1 || NUM_EN > MEM_DIV) begin : g_bad_num_en
        $fatal(1, "cpu_seq_ctrl: NUM_EN must be in 1..MEM_DIV");
    end
    if (FLUSH_CYC < 1) begin : g_bad_flush_cyc
        $fatal(1, "cpu_seq_ctrl: FLUSH_CYC must be at least 1");
    end
    if (HALT_CYC < 2) begin : g_bad_halt_cyc
        $fatal(1, "cpu_seq_ctrl: HALT_CYC must be at least 2");
    end

    localparam int PH_W = width_for(MEM_DIV - 1);
    localparam int FL_W = width_for(FLUSH_CYC - 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(MEM_DIV - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYC - 1);

    state_t            state, next_state;
    logic [PH_W-1:0]   phase, next_phase;
    logic [FL_W-1:0]   flush_cnt, next_flush_cnt;
    logic              stall_hit;
    logic              cpu_rst_d, running_d, halted_d;
    logic [NUM_EN-1:0] memen_d;

    pc_watchdog #(
        .PC_W     (PC_W),
        .HALT_CYC (HALT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .enable    (state == RUN),
        .clear     (restart),
        .pc        (pc),
        .stall_hit (stall_hit)
    );

    // Outputs are loaded from the next-state decode, so they are flops that
    // always agree with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            phase     <= '0;
            cpu_rst   <= 1'b1;
            memen     <= '0;
            running   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_flush_cnt;
            phase     <= next_phase;
            cpu_rst   <= cpu_rst_d;
            memen     <= memen_d;
            running   <= running_d;
            halted    <= halted_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        next_state     = state;
        next_phase     = phase;
        next_flush_cnt = flush_cnt;
        unique case (state)
            FLUSH: begin
                next_phase = '0;
                if (restart) begin
                    next_flush_cnt = '0;
                end else if (flush_cnt == FL_LAST) begin
                    next_state     = RUN;
                    next_flush_cnt = '0;
                end else begin
                    next_flush_cnt = flush_cnt + FL_W'(1);
                end
            end
            RUN: begin
                // Restart outranks a halt detected on the same edge.
                if (restart) begin
                    next_state     = FLUSH;
                    next_flush_cnt = '0;
                    next_phase     = '0;
                end else if (stall_hit) begin
                    next_state = HALT;
                    next_phase = '0;
                end else if (phase == PH_LAST) begin
                    next_phase = '0;
                end else begin
                    next_phase = phase + PH_W'(1);
                end
            end
            HALT: begin
                if (restart) begin
                    next_state     = FLUSH;
                    next_flush_cnt = '0;
                end
            end
            default: begin
                next_state     = FLUSH;
                next_flush_cnt = '0;
                next_phase     = '0;
            end
        endcase
    end

    always_comb begin
        cpu_rst_d = (next_state == FLUSH);
        running_d = (next_state == RUN);
        halted_d  = (next_state == HALT);
        memen_d   = '0;
        for (int i = 0; i < NUM_EN; i++) begin
            memen_d[i] = running_d && (next_phase == PH_W'(i));
        end
    end

`ifdef CPU_SEQ_CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
        end else if (next_state == FLUSH) begin
            cyc_cnt <= '0;
        end else if (state == RUN && cyc_cnt != CYC_MAX) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`else
    assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: three configurations driven in lockstep; a cycle-level
// reference model fills per-configuration scoreboards that a negedge monitor drains.
module tb_cpu_seq_ctrl;

    localparam int PC_W = 6;
    localparam int N    = 3;

    localparam int A_DIV = 2, A_EN = 1, A_FL = 1, A_HC = 8;
    localparam int B_DIV = 4, B_EN = 3, B_FL = 3, B_HC = 5;
    localparam int C_DIV = 1, C_EN = 1, C_FL = 2, C_HC = 2;

    localparam int DIVS [N] = '{A_DIV, B_DIV, C_DIV};
    localparam int ENS  [N] = '{A_EN, B_EN, C_EN};
    localparam int FLS  [N] = '{A_FL, B_FL, C_FL};
    localparam int HCS  [N] = '{A_HC, B_HC, C_HC};

    typedef enum int {M_FLUSH, M_RUN, M_HALT} mode_e;

    typedef struct {
        mode_e  mode;
        int     fdone;
        int     run_cyc;
        int     stall;
        int     prev_pc;
        longint cyc;
    } model_t;

    typedef struct packed {
        logic        cpu_rst;
        logic [3:0]  memen;
        logic        running;
        logic        halted;
        logic [31:0] cyc;
    } obs_t;

    logic            clk     = 1'b0;
    logic            reset   = 1'b0;
    logic            restart = 1'b0;
    logic [PC_W-1:0] pc      = '0;

    logic [N-1:0]       cpu_rst, running, halted;
    logic [N-1:0][31:0] cyc_cnt;
    logic [A_EN-1:0]    memen_a;
    logic [B_EN-1:0]    memen_b;
    logic [C_EN-1:0]    memen_c;

    obs_t   got   [N];
    model_t mdl   [N];
    obs_t   exp_q [N][$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_on = 1'b0;

    always #5 clk = ~clk;

    cpu_seq_ctrl dut_a (
        .clk(clk), .reset(reset), .pc(pc), .restart(restart),
        .cpu_rst(cpu_rst[0]), .memen(memen_a), .running(running[0]),
        .halted(halted[0]), .cyc_cnt(cyc_cnt[0])
    );

    cpu_seq_ctrl #(
        .PC_W(PC_W), .MEM_DIV(B_DIV), .NUM_EN(B_EN), .FLUSH_CYC(B_FL), .HALT_CYC(B_HC)
    ) dut_b (
        .clk(clk), .reset(reset), .pc(pc), .restart(restart),
        .cpu_rst(cpu_rst[1]), .memen(memen_b), .running(running[1]),
        .halted(halted[1]), .cyc_cnt(cyc_cnt[1])
    );

    cpu_seq_ctrl #(
        .PC_W(PC_W), .MEM_DIV(C_DIV), .NUM_EN(C_EN), .FLUSH_CYC(C_FL), .HALT_CYC(C_HC)
    ) dut_c (
        .clk(clk), .reset(reset), .pc(pc), .restart(restart),
        .cpu_rst(cpu_rst[2]), .memen(memen_c), .running(running[2]),
        .halted(halted[2]), .cyc_cnt(cyc_cnt[2])
    );

    assign got[0] = {cpu_rst[0], 3'b000, memen_a, running[0], halted[0], cyc_cnt[0]};
    assign got[1] = {cpu_rst[1], 1'b0,   memen_b, running[1], halted[1], cyc_cnt[1]};
    assign got[2] = {cpu_rst[2], 3'b000, memen_c, running[2], halted[2], cyc_cnt[2]};

    // ---------------- reference model ----------------
    function automatic model_t model_reset();
        model_t m;
        m.mode    = M_FLUSH;
        m.fdone   = 0;
        m.run_cyc = 0;
        m.stall   = 0;
        m.prev_pc = 0;
        m.cyc     = 0;
        return m;
    endfunction

    function automatic model_t enter_flush(input model_t m);
        model_t r;
        r       = m;
        r.mode  = M_FLUSH;
        r.fdone = 0;
        r.stall = 0;
        r.cyc   = 0;
        return r;
    endfunction

    // One clock edge: pc_v and rs are the inputs present at that edge.
    function automatic model_t model_step(input model_t m, input int pc_v, input logic rs,
                                          input int hc, input int fc);
        model_t r;
        r = m;
        case (m.mode)
            M_FLUSH: begin
                r.stall = 0;
                if (rs) begin
                    r.fdone = 0;
                end else begin
                    r.fdone = m.fdone + 1;
                    if (r.fdone == fc) begin
                        r.mode    = M_RUN;
                        r.run_cyc = 0;
                    end
                end
            end
            M_RUN: begin
                r.stall = (pc_v == m.prev_pc) ? m.stall + 1 : 0;
                if (rs) begin
                    r = enter_flush(r);
                end else begin
                    if (m.cyc < 64'hFFFF_FFFF) r.cyc = m.cyc + 1;
                    if (r.stall == hc) begin
                        r.mode  = M_HALT;
                        r.stall = 0;
                    end else begin
                        r.run_cyc = m.run_cyc + 1;
                    end
                end
            end
            default: begin
                r.stall = 0;
                if (rs) r = enter_flush(r);
            end
        endcase
        r.prev_pc = pc_v;
        return r;
    endfunction

    function automatic obs_t model_out(input model_t m, input int div, input int en);
        obs_t o;
        int   ph;
        o         = '0;
        o.cpu_rst = (m.mode == M_FLUSH);
        o.running = (m.mode == M_RUN);
        o.halted  = (m.mode == M_HALT);
        ph        = m.run_cyc % div;
        if (m.mode == M_RUN && ph < en) o.memen[ph] = 1'b1;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
        o.cyc = 32'(m.cyc);
`endif
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input int i, input obs_t g, input obs_t e);
        check($sformatf("cfg%0d_cpu_rst", i), 64'(g.cpu_rst), 64'(e.cpu_rst));
        check($sformatf("cfg%0d_memen", i),   64'(g.memen),   64'(e.memen));
        check($sformatf("cfg%0d_running", i), 64'(g.running), 64'(e.running));
        check($sformatf("cfg%0d_halted", i),  64'(g.halted),  64'(e.halted));
        check($sformatf("cfg%0d_cyc_cnt", i), 64'(g.cyc),     64'(e.cyc));
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        if (mon_on) begin
            for (int i = 0; i < N; i++) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("cfg%0d_scoreboard_empty", i), 64'd0, 64'd1);
                end else begin
                    e = exp_q[i].pop_front();
                    compare(i, got[i], e);
                end
            end
            check("cfg1_memen_onehot0", {63'd0, $onehot0(memen_b)}, 64'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [PC_W-1:0] npc, input logic nrs, input logic nreset);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!reset) mdl[i] = model_reset();
            else        mdl[i] = model_step(mdl[i], int'(pc), restart, HCS[i], FLS[i]);
            exp_q[i].push_back(model_out(mdl[i], DIVS[i], ENS[i]));
        end
        #1;
        pc      = npc;
        restart = nrs;
        reset   = nreset;
    endtask

    // Reset falls between edges; the following negedge must already show reset values.
    task automatic drop_reset_mid();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            mdl[i] = model_step(mdl[i], int'(pc), restart, HCS[i], FLS[i]);
        end
        #2;
        reset   = 1'b0;
        restart = 1'b0;
        for (int i = 0; i < N; i++) begin
            mdl[i] = model_reset();
            exp_q[i].push_back(model_out(mdl[i], DIVS[i], ENS[i]));
        end
    endtask

    initial begin : watchdog_timer
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin : driver
        logic [PC_W-1:0] p;
        int              hold;
        int              r;
        for (int i = 0; i < N; i++) mdl[i] = model_reset();
        p      = '0;
        hold   = 0;
        mon_on = 1'b1;

        // Reset held, then released; startup flush and enable pattern.
        step(p, 1'b0, 1'b0);
        step(p, 1'b0, 1'b0);
        step(p, 1'b0, 1'b1);
        repeat (12) begin
            p = p + 6'd1;
            step(p, 1'b0, 1'b1);
        end

        // Count up to 17 and stick there until every configuration halts.
        while (p != 6'd17) begin
            p = p + 6'd1;
            step(p, 1'b0, 1'b1);
        end
        repeat (20) step(p, 1'b0, 1'b1);

        // Restart out of HALT, then run again.
        step(p, 1'b1, 1'b1);
        repeat (12) begin
            p = p + 6'd1;
            step(p, 1'b0, 1'b1);
        end

        // Restart timed to the edge on which the default stall count reaches HALT_CYC.
        repeat (40) begin
            step(p, 1'b0, 1'b1);
            if (mdl[0].mode == M_RUN && mdl[0].stall == HCS[0] - 1) restart = 1'b1;
        end
        repeat (6) begin
            p = p + 6'd1;
            step(p, 1'b0, 1'b1);
        end

        // Randomised mix of counting, jumps, stalls and restarts.
        repeat (3000) begin
            r = int'($urandom_range(0, 99));
            if (hold > 0) begin
                hold--;
            end else if (r < 15) begin
                hold = int'($urandom_range(1, 12));
            end else if (r < 85) begin
                p = p + 6'd1;
            end else begin
                p = PC_W'($urandom);
            end
            step(p, ($urandom_range(0, 39) == 0), 1'b1);
        end

        // Asynchronous reset in the middle of RUN.
        step(p, 1'b1, 1'b1);
        repeat (6) begin
            p = p + 6'd1;
            step(p, 1'b0, 1'b1);
        end
        drop_reset_mid();
        step(p, 1'b0, 1'b0);
        step(p, 1'b0, 1'b1);
        repeat (10) begin
            p = p + 6'd1;
            step(p, 1'b0, 1'b1);
        end

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("cfg%0d_scoreboard_drained", i), 64'(exp_q[i].size()), 64'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
